// File: rtl/reg_access_ctrl.sv
// Operand-fetch controller for a 2R/1W synchronous register file: issues reads,
// corrects for in-flight writes (when REG_ACCESS_BYPASS_EN is defined), and hands operands on.
module reg_access_ctrl #(
   parameter int unsigned WORD_W = 8,
   parameter int unsigned ADDR_W = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic [ADDR_W-1:0] req_src1,
   input  logic [ADDR_W-1:0] req_src2,
   input  logic [ADDR_W-1:0] req_dst,
   input  logic              wb_valid,
   input  logic [ADDR_W-1:0] wb_addr,
   input  logic [WORD_W-1:0] wb_data,
   output logic [ADDR_W-1:0] rf_rd_addr1,
   output logic [ADDR_W-1:0] rf_rd_addr2,
   input  logic [WORD_W-1:0] rf_rd_data1,
   input  logic [WORD_W-1:0] rf_rd_data2,
   output logic [ADDR_W-1:0] rf_wr_addr,
   output logic [WORD_W-1:0] rf_wr_data,
   output logic              rf_wr_en,
   output logic              op_valid,
   input  logic              op_ready,
   output logic [WORD_W-1:0] op_a,
   output logic [WORD_W-1:0] op_b,
   output logic [ADDR_W-1:0] op_dst
);

   typedef enum logic [1:0] {IDLE, ADDR, DATA, OUT} state_t;

   state_t              state_q, state_d;
   logic [ADDR_W-1:0]   src1_q, src1_d;
   logic [ADDR_W-1:0]   src2_q, src2_d;
   logic [ADDR_W-1:0]   dst_q, dst_d;
   logic                op_valid_q, op_valid_d;
   logic [WORD_W-1:0]   op_a_q, op_a_d;
   logic [WORD_W-1:0]   op_b_q, op_b_d;
   logic [ADDR_W-1:0]   op_dst_q, op_dst_d;

`ifdef REG_ACCESS_BYPASS_EN
   logic                fwd1_v_q, fwd1_v_d;
   logic                fwd2_v_q, fwd2_v_d;
   logic [WORD_W-1:0]   fwd1_q, fwd1_d;
   logic [WORD_W-1:0]   fwd2_q, fwd2_d;
   logic                wb_hit1, wb_hit2;

   assign wb_hit1 = wb_valid && (wb_addr == src1_q);
   assign wb_hit2 = wb_valid && (wb_addr == src2_q);
`endif

   assign req_ready   = (state_q == IDLE) && !rst;
   assign rf_rd_addr1 = src1_q;
   assign rf_rd_addr2 = src2_q;
   assign rf_wr_en    = wb_valid && !rst;
   assign rf_wr_addr  = wb_addr;
   assign rf_wr_data  = wb_data;
   assign op_valid    = op_valid_q;
   assign op_a        = op_a_q;
   assign op_b        = op_b_q;
   assign op_dst      = op_dst_q;

   always_comb begin
      state_d    = state_q;
      src1_d     = src1_q;
      src2_d     = src2_q;
      dst_d      = dst_q;
      op_valid_d = op_valid_q;
      op_a_d     = op_a_q;
      op_b_d     = op_b_q;
      op_dst_d   = op_dst_q;
`ifdef REG_ACCESS_BYPASS_EN
      fwd1_v_d   = fwd1_v_q;
      fwd2_v_d   = fwd2_v_q;
      fwd1_d     = fwd1_q;
      fwd2_d     = fwd2_q;
`endif
      case (state_q)
         IDLE: begin
            if (req_valid) begin
               src1_d  = req_src1;
               src2_d  = req_src2;
               dst_d   = req_dst;
               state_d = ADDR;
            end
         end
         ADDR: begin
            state_d = DATA;
`ifdef REG_ACCESS_BYPASS_EN
            // Reg file samples the old value at this edge; remember the write instead.
            fwd1_v_d = wb_hit1;
            fwd2_v_d = wb_hit2;
            if (wb_hit1) fwd1_d = wb_data;
            if (wb_hit2) fwd2_d = wb_data;
`endif
         end
         DATA: begin
            state_d    = OUT;
            op_valid_d = 1'b1;
            op_dst_d   = dst_q;
            op_a_d     = rf_rd_data1;
            op_b_d     = rf_rd_data2;
`ifdef REG_ACCESS_BYPASS_EN
            if (wb_hit1)       op_a_d = wb_data;
            else if (fwd1_v_q) op_a_d = fwd1_q;
            if (wb_hit2)       op_b_d = wb_data;
            else if (fwd2_v_q) op_b_d = fwd2_q;
`endif
         end
         OUT: begin
`ifdef REG_ACCESS_BYPASS_EN
            if (wb_hit1) op_a_d = wb_data;
            if (wb_hit2) op_b_d = wb_data;
`endif
            if (op_ready) begin
               op_valid_d = 1'b0;
               state_d    = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= IDLE;
         src1_q     <= '0;
         src2_q     <= '0;
         dst_q      <= '0;
         op_valid_q <= 1'b0;
         op_a_q     <= '0;
         op_b_q     <= '0;
         op_dst_q   <= '0;
`ifdef REG_ACCESS_BYPASS_EN
         fwd1_v_q   <= 1'b0;
         fwd2_v_q   <= 1'b0;
         fwd1_q     <= '0;
         fwd2_q     <= '0;
`endif
      end else begin
         state_q    <= state_d;
         src1_q     <= src1_d;
         src2_q     <= src2_d;
         dst_q      <= dst_d;
         op_valid_q <= op_valid_d;
         op_a_q     <= op_a_d;
         op_b_q     <= op_b_d;
         op_dst_q   <= op_dst_d;
`ifdef REG_ACCESS_BYPASS_EN
         fwd1_v_q   <= fwd1_v_d;
         fwd2_v_q   <= fwd2_v_d;
         fwd1_q     <= fwd1_d;
         fwd2_q     <= fwd2_d;
`endif
      end
   end

endmodule

// File: tb/tb_reg_access_ctrl.sv
// Bench for reg_access_ctrl: register-file model, architectural model checked every
// cycle, and directed scenarios with literal expectations for both bypass builds.
module tb_reg_access_ctrl;

   localparam int unsigned WORD_W = 8;
   localparam int unsigned ADDR_W = 2;

   logic              clk = 1'b0;
   logic              rst;
   logic              req_valid;
   logic              req_ready;
   logic [ADDR_W-1:0] req_src1, req_src2, req_dst;
   logic              wb_valid;
   logic [ADDR_W-1:0] wb_addr;
   logic [WORD_W-1:0] wb_data;
   logic [ADDR_W-1:0] rf_rd_addr1, rf_rd_addr2;
   logic [WORD_W-1:0] rf_rd_data1, rf_rd_data2;
   logic [ADDR_W-1:0] rf_wr_addr;
   logic [WORD_W-1:0] rf_wr_data;
   logic              rf_wr_en;
   logic              op_valid;
   logic              op_ready;
   logic [WORD_W-1:0] op_a, op_b;
   logic [ADDR_W-1:0] op_dst;

   int n_pass = 0;
   int n_total = 0;

`ifdef REG_ACCESS_BYPASS_EN
   localparam bit BYP = 1'b1;
`else
   localparam bit BYP = 1'b0;
`endif

   reg_access_ctrl #(.WORD_W(WORD_W), .ADDR_W(ADDR_W)) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(req_ready),
      .req_src1(req_src1), .req_src2(req_src2), .req_dst(req_dst),
      .wb_valid(wb_valid), .wb_addr(wb_addr), .wb_data(wb_data),
      .rf_rd_addr1(rf_rd_addr1), .rf_rd_addr2(rf_rd_addr2),
      .rf_rd_data1(rf_rd_data1), .rf_rd_data2(rf_rd_data2),
      .rf_wr_addr(rf_wr_addr), .rf_wr_data(rf_wr_data), .rf_wr_en(rf_wr_en),
      .op_valid(op_valid), .op_ready(op_ready),
      .op_a(op_a), .op_b(op_b), .op_dst(op_dst)
   );

   always #5 clk = ~clk;

   // Synchronous register file: registered read returns the pre-write value.
   logic [WORD_W-1:0] mem [4];
   initial begin
      for (int i = 0; i < 4; i++) mem[i] = '0;
      rf_rd_data1 = '0;
      rf_rd_data2 = '0;
   end
   always @(posedge clk) begin
      rf_rd_data1 <= mem[rf_rd_addr1];
      rf_rd_data2 <= mem[rf_rd_addr2];
      if (rf_wr_en) mem[rf_wr_addr] <= rf_wr_data;
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   // Architectural model: register contents plus where the request is in its life.
   logic [WORD_W-1:0] arch [4];
   logic [WORD_W-1:0] pre  [4];
   int                age = -1;
   bit                m_ok = 1'b0;
   logic              m_valid;
   logic [WORD_W-1:0] m_a, m_b, snap_a, snap_b;
   logic [ADDR_W-1:0] m_s1, m_s2, m_d, m_dst;
   initial for (int i = 0; i < 4; i++) arch[i] = '0;

   always @(posedge clk) begin
      for (int i = 0; i < 4; i++) pre[i] = arch[i];
      if (wb_valid && !rst) arch[wb_addr] = wb_data;
      if (rst) begin
         age = -1; m_ok = 1'b1; m_valid = 1'b0;
         m_a = '0; m_b = '0; m_dst = '0; m_s1 = '0; m_s2 = '0; m_d = '0;
      end else if (age == -1) begin
         if (req_valid) begin
            age = 0; m_s1 = req_src1; m_s2 = req_src2; m_d = req_dst;
         end
      end else if (age == 0) begin
         age = 1; snap_a = pre[m_s1]; snap_b = pre[m_s2];
      end else if (age == 1) begin
         age = 2; m_valid = 1'b1; m_dst = m_d;
         m_a = BYP ? arch[m_s1] : snap_a;
         m_b = BYP ? arch[m_s2] : snap_b;
      end else begin
         if (BYP) begin
            m_a = arch[m_s1]; m_b = arch[m_s2];
         end
         if (op_ready) begin
            m_valid = 1'b0; age = -1;
         end
      end
   end

   always @(negedge clk) begin
      if (m_ok) begin
         chk("req_ready",   32'(req_ready),   32'(age == -1 && !rst));
         chk("op_valid",    32'(op_valid),    32'(m_valid));
         chk("op_a",        32'(op_a),        32'(m_a));
         chk("op_b",        32'(op_b),        32'(m_b));
         chk("op_dst",      32'(op_dst),      32'(m_dst));
         chk("rf_rd_addr1", 32'(rf_rd_addr1), 32'(m_s1));
         chk("rf_rd_addr2", 32'(rf_rd_addr2), 32'(m_s2));
         chk("rf_wr_en",    32'(rf_wr_en),    32'(wb_valid && !rst));
         chk("rf_wr_addr",  32'(rf_wr_addr),  32'(wb_addr));
         chk("rf_wr_data",  32'(rf_wr_data),  32'(wb_data));
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic wb(input logic [ADDR_W-1:0] a, input logic [WORD_W-1:0] d);
      wb_valid = 1'b1; wb_addr = a; wb_data = d;
      step();
      wb_valid = 1'b0;
   endtask

   task automatic accept(input logic [ADDR_W-1:0] s1, input logic [ADDR_W-1:0] s2,
                         input logic [ADDR_W-1:0] d);
      req_valid = 1'b1; req_src1 = s1; req_src2 = s2; req_dst = d;
      step();
      req_valid = 1'b0;
   endtask

   initial begin
      rst = 1'b1; req_valid = 1'b0; req_src1 = '0; req_src2 = '0; req_dst = '0;
      wb_valid = 1'b0; wb_addr = '0; wb_data = '0; op_ready = 1'b1;
      step(); step();
      chk("rst_op_valid", 32'(op_valid), 32'd0);
      chk("rst_op_a", 32'(op_a), 32'd0);
      rst = 1'b0;
      #1;
      chk("rst_req_ready", 32'(req_ready), 32'd1);

      // Basic fetch
      wb(2'd1, 8'h11);
      wb(2'd2, 8'h22);
      accept(2'd1, 2'd2, 2'd3);
      chk("t1_req_ready_busy", 32'(req_ready), 32'd0);
      step();
      chk("t1_no_valid_yet", 32'(op_valid), 32'd0);
      step();
      chk("t1_op_valid", 32'(op_valid), 32'd1);
      chk("t1_op_a", 32'(op_a), 32'h11);
      chk("t1_op_b", 32'(op_b), 32'h22);
      chk("t1_op_dst", 32'(op_dst), 32'd3);
      step();
      chk("t1_done_valid", 32'(op_valid), 32'd0);
      chk("t1_done_ready", 32'(req_ready), 32'd1);

      // Write at E1
      accept(2'd1, 2'd2, 2'd0);
      wb(2'd1, 8'hA5);
      step();
      chk("t2_op_a_e1", 32'(op_a), BYP ? 32'hA5 : 32'h11);
      step();

      // E1 then E2 writes to the same register
      accept(2'd1, 2'd2, 2'd1);
      wb(2'd2, 8'h33);
      wb(2'd2, 8'h5A);
      chk("t3_op_b_e2", 32'(op_b), BYP ? 32'h5A : 32'h22);
      chk("t3_op_a", 32'(op_a), 32'hA5);
      step();

      // Held operands under back-pressure
      op_ready = 1'b0;
      accept(2'd1, 2'd2, 2'd2);
      step(); step();
      chk("t4_valid", 32'(op_valid), 32'd1);
      step(); step();
      wb(2'd1, 8'hC3);
      step(); step();
      chk("t4_hold_valid", 32'(op_valid), 32'd1);
      chk("t4_op_a", 32'(op_a), BYP ? 32'hC3 : 32'hA5);
      chk("t4_op_b", 32'(op_b), 32'h5A);
      chk("t4_op_dst", 32'(op_dst), 32'd2);
      op_ready = 1'b1;
      step();
      chk("t4_release", 32'(op_valid), 32'd0);
      chk("t4_idle", 32'(req_ready), 32'd1);

      // src1 == src2 with E1 write
      wb(2'd0, 8'h00);
      accept(2'd0, 2'd0, 2'd1);
      wb(2'd0, 8'hFF);
      step();
      chk("t5_op_a", 32'(op_a), BYP ? 32'hFF : 32'h00);
      chk("t5_op_b", 32'(op_b), BYP ? 32'hFF : 32'h00);
      step();

      // Reset in DATA with a write pending
      accept(2'd1, 2'd2, 2'd3);
      step();
      rst = 1'b1; wb_valid = 1'b1; wb_addr = 2'd3; wb_data = 8'h77;
      #1;
      chk("t6_wr_blocked", 32'(rf_wr_en), 32'd0);
      step();
      rst = 1'b0; wb_valid = 1'b0;
      #1;
      chk("t6_valid_cleared", 32'(op_valid), 32'd0);
      chk("t6_req_ready", 32'(req_ready), 32'd1);
      for (int i = 0; i < 5; i++) begin
         step();
         chk("t6_no_stale", 32'(op_valid), 32'd0);
      end

      // Write on the acceptance edge is seen by the read; r3 was never written
      req_valid = 1'b1; req_src1 = 2'd3; req_src2 = 2'd2; req_dst = 2'd0;
      wb_valid = 1'b1; wb_addr = 2'd2; wb_data = 8'h44;
      step();
      req_valid = 1'b0; wb_valid = 1'b0;
      step(); step();
      chk("t7_op_a", 32'(op_a), 32'h00);
      chk("t7_op_b", 32'(op_b), 32'h44);
      step(); step();

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/reg_access_ctrl.md
Name: reg_access_ctrl

Overview:
Initiator-side controller for the 2-read/1-write synchronous register file. It accepts operand-fetch requests from the decoder and drives the register file read addresses. It captures the registered read data, corrects it for writes that land in the same cycles, and presents operands to the ALU stage on a valid/ready handshake. It also passes the writeback stream through to the register file write port.

Parameters:
WORD_W, 8, data word width (matches word)
ADDR_W, 2, register address width (matches regAddr; 2**ADDR_W registers)

Ports:
clk  in  1  system clock, all state on posedge
rst  in  1  synchronous active-high reset
req_valid  in  1  fetch request valid
req_ready  out  1  controller can accept request
req_src1  in  ADDR_W  operand A register
req_src2  in  ADDR_W  operand B register
req_dst  in  ADDR_W  destination tag, passed through
wb_valid  in  1  writeback valid
wb_addr  in  ADDR_W  writeback register
wb_data  in  WORD_W  writeback data
rf_rd_addr1  out  ADDR_W  to reg file read port 1
rf_rd_addr2  out  ADDR_W  to reg file read port 2
rf_rd_data1  in  WORD_W  from reg file, registered (1 clk after address)
rf_rd_data2  in  WORD_W  from reg file, registered
rf_wr_addr  out  ADDR_W  to reg file write address
rf_wr_data  out  WORD_W  to reg file write data
rf_wr_en  out  1  to reg file write enable
op_valid  out  1  operands valid
op_ready  in  1  consumer accepts operands
op_a  out  WORD_W  operand A
op_b  out  WORD_W  operand B
op_dst  out  ADDR_W  destination tag

Behaviour:
- Clock clk; reset rst is synchronous, active-high.
- FSM states: IDLE, ADDR, DATA, OUT. Reset state is IDLE.
- Reset values: op_valid=0, op_a=0, op_b=0, op_dst=0, rf_rd_addr1/2=0, all forward flags cleared.
- req_ready is 1 only in IDLE with rst=0.
- IDLE: on req_valid&&req_ready, register src1/src2/dst and go to ADDR.
- rf_rd_addr1/2 are driven from the registered src fields, so they are stable from ADDR through OUT.
- ADDR -> DATA unconditionally. The reg file samples the addresses at this edge (E1).
- DATA -> OUT unconditionally. rf_rd_data is captured into op_a/op_b at this edge (E2), and op_valid is set.
- OUT: hold all op_* outputs while op_ready=0. When op_ready=1, clear op_valid and go to IDLE.
- Latency: op_valid rises 2 edges after the acceptance edge. Throughput is one op per 4 cycles when op_ready is held high.
- Write path is combinational pass-through: rf_wr_en = wb_valid & ~rst, rf_wr_addr = wb_addr, rf_wr_data = wb_data.
- Write at edge E0 (acceptance) or earlier: no action; the reg file already returns the new value.
- Write at E1 matching a src: the reg file returns the old value. Latch wb_data into a per-operand forward register, set the flag, and substitute at E2.
- Write at E2 matching a src: op captures wb_data directly. This overrides the E1 forward.
- Write during OUT matching a src: the held op_a/op_b is updated with wb_data at that edge. Held operands always equal the current register contents.
- The update applies even on the handshake edge; the consumer samples pre-edge values.
- src1==src2: both operands receive identical forwarding.
- op_dst has no forwarding; it is a pure tag.
- rst in any state: next state IDLE, op_valid=0, in-flight request dropped, no write issued that cycle.
- Arithmetic: none. All widths are exact and there is no truncation.

Optional Feature:
REG_ACCESS_BYPASS_EN
- Defined: E1/E2/OUT forwarding and held-operand updates as above.
- Undefined: all forwarding logic removed. op_a/op_b equal the raw rf_rd_data captured at E2 and held unchanged in OUT. Writes at E1 and E2 yield stale values, and software must insert gaps.
- All other timing is identical in both builds.

Test Plan:
- Reset then preload r1=8'h11, r2=8'h22 via wb; req src1=1, src2=2, dst=3; op_ready=1 -> op_valid 2 edges after accept, op_a=11, op_b=22, op_dst=3, req_ready low until return to IDLE.
- r1=8'h11; write r1=8'hA5 at E1 -> op_a=A5 with BYPASS_EN, 11 without.
- r2=8'h22; write r2=8'h5A at E2, with an earlier write r2=8'h33 at E1 -> op_b=5A (E2 wins).
- op_ready=0 for 5 cycles in OUT; write src1 reg=8'hC3 at cycle 3 -> op_a changes to C3, op_b/op_dst stable, op_valid stays 1; op_ready=1 -> IDLE.
- src1=src2=0, r0=8'h00, write r0=8'hFF at E1 -> op_a=op_b=FF.
- Assert rst in DATA with wb_valid=1 -> rf_wr_en=0 that cycle; next cycle IDLE, op_valid=0, req_ready=1, no stale op later emitted.
